// File: rtl/direction_determiner_reg.sv
// direction_determiner_reg: registered route decision for one BFT switch node.
// Classifies each flit's destination leaf as VOID / LEFT / RIGHT / UP relative
// to this node's subtree, registers the result with the flit, and keeps
// saturating per-direction decision counters for debug.
module direction_determiner_reg #(
    parameter int                               num_leaves  = 2,
    parameter int                               level       = 0,
    parameter logic [((level > 0) ? level : 1)-1:0] module_addr = '0,
    parameter int                               cnt_w       = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          valid_in,
    input  logic [$clog2(num_leaves)-1:0] addr_in,
    output logic [1:0]                    d,
    output logic                          valid_out,
    output logic [$clog2(num_leaves)-1:0] addr_out,
    output logic [cnt_w-1:0]              cnt_left,
    output logic [cnt_w-1:0]              cnt_right,
    output logic [cnt_w-1:0]              cnt_up,
    input  logic                          cnt_clr
);

    localparam int A = $clog2(num_leaves);

    typedef enum logic [1:0] {
        DIR_VOID  = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    logic         match;
    logic         branch_bit;
    dir_t         nd;
    logic [1:0]   d_d, d_q;
    logic         valid_d, valid_q;
    logic [A-1:0] addr_d, addr_q;
    logic [2:0][cnt_w-1:0] cnt_all;

    // The root owns every leaf, so only inner nodes compare an address prefix.
    generate
        if (level == 0) begin : g_root
            assign match = 1'b1;
        end else begin : g_inner
            assign match = (addr_in[A-1 -: level] == module_addr);
        end
    endgenerate

    // The bit just below the node prefix selects the left or right child.
    assign branch_bit = addr_in[A-1-level];

    // Next-direction decode; invalid flits never route anywhere.
    always_comb begin
        nd = DIR_VOID;
        if (valid_in) begin
            if (!match) begin
                nd = DIR_UP;
            end else if (branch_bit) begin
                nd = DIR_RIGHT;
            end else begin
                nd = DIR_LEFT;
            end
        end
    end

    // Pipeline register inputs: decision plus verbatim copies of the flit.
    always_comb begin
        d_d     = nd;
        valid_d = valid_in;
        addr_d  = addr_in;
    end

    // One-cycle output register with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q     <= 2'b00;
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            d_q     <= d_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    // Counter gi tracks direction code gi+1 (LEFT, RIGHT, UP); VOID is not counted.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            localparam logic [1:0] DIR_CODE = 2'(gi + 1);
            logic [cnt_w-1:0] cnt_d, cnt_q;

            // Clear wins over increment; counting stops at all-ones.
            always_comb begin
                cnt_d = cnt_q;
                if (cnt_clr) begin
                    cnt_d = '0;
                end else if ((d_d == DIR_CODE) && (cnt_q != {cnt_w{1'b1}})) begin
                    cnt_d = cnt_q + cnt_w'(1);
                end
            end

            // Counter state register with asynchronous clear.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_all[gi] = cnt_q;
        end
    endgenerate

    assign d         = d_q;
    assign valid_out = valid_q;
    assign addr_out  = addr_q;
    assign cnt_left  = cnt_all[0];
    assign cnt_right = cnt_all[1];
    assign cnt_up    = cnt_all[2];

endmodule

// File: tb/tb_direction_determiner_reg.sv
// Directed bench for direction_determiner_reg: four configurations share one
// clock and reset; each scenario task drives its DUT and checks inline.
module tb_direction_determiner_reg;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // u0: 128 leaves, root
    logic v0 = 1'b0, c0 = 1'b0;
    logic [6:0] a0 = '0, ao0;
    logic [1:0] d0; logic vo0;
    logic [15:0] l0, r0, u0c;
    // u1: 16 leaves, level 2, addr 2'b10
    logic v1 = 1'b0, c1 = 1'b0;
    logic [3:0] a1 = '0, ao1;
    logic [1:0] d1; logic vo1;
    logic [15:0] l1, r1, u1c;
    // u2: 8 leaves, level 2, addr 2'b01
    logic v2 = 1'b0, c2 = 1'b0;
    logic [2:0] a2 = '0, ao2;
    logic [1:0] d2; logic vo2;
    logic [15:0] l2, r2, u2c;
    // u3: 16 leaves, level 2, addr 2'b10, 2-bit counters
    logic v3 = 1'b0, c3 = 1'b0;
    logic [3:0] a3 = '0, ao3;
    logic [1:0] d3; logic vo3;
    logic [1:0] l3, r3, u3c;

    direction_determiner_reg #(.num_leaves(128), .level(0), .module_addr(1'b0), .cnt_w(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .valid_in(v0), .addr_in(a0), .d(d0), .valid_out(vo0),
        .addr_out(ao0), .cnt_left(l0), .cnt_right(r0), .cnt_up(u0c), .cnt_clr(c0));
    direction_determiner_reg #(.num_leaves(16), .level(2), .module_addr(2'b10), .cnt_w(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .valid_in(v1), .addr_in(a1), .d(d1), .valid_out(vo1),
        .addr_out(ao1), .cnt_left(l1), .cnt_right(r1), .cnt_up(u1c), .cnt_clr(c1));
    direction_determiner_reg #(.num_leaves(8), .level(2), .module_addr(2'b01), .cnt_w(16)) dut2 (
        .clk(clk), .reset_n(reset_n), .valid_in(v2), .addr_in(a2), .d(d2), .valid_out(vo2),
        .addr_out(ao2), .cnt_left(l2), .cnt_right(r2), .cnt_up(u2c), .cnt_clr(c2));
    direction_determiner_reg #(.num_leaves(16), .level(2), .module_addr(2'b10), .cnt_w(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .valid_in(v3), .addr_in(a3), .d(d3), .valid_out(vo3),
        .addr_out(ao3), .cnt_left(l3), .cnt_right(r3), .cnt_up(u3c), .cnt_clr(c3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests++;
        if ({d0, vo0, ao0, l0, r0, u0c} !== '0) begin
            fails++; $display("FAIL reset_u0 got d=%0d v=%0d a=%0d l=%0d r=%0d u=%0d want all 0", d0, vo0, ao0, l0, r0, u0c);
        end
        tests++;
        if ({d3, vo3, ao3, l3, r3, u3c} !== '0) begin
            fails++; $display("FAIL reset_u3 got d=%0d v=%0d a=%0d l=%0d r=%0d u=%0d want all 0", d3, vo3, ao3, l3, r3, u3c);
        end
        $display("[TB] reset: outputs checked while reset_n low");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_idle_sweep();
        for (int i = 0; i <= 10; i++) begin
            v0 = 1'b0; a0 = 7'(i);
            tick();
            tests++;
            if (d0 !== 2'b00 || vo0 !== 1'b0 || ao0 !== 7'(i)) begin
                fails++; $display("FAIL idle_%0d got d=%0d v=%0d a=%0d want d=0 v=0 a=%0d", i, d0, vo0, ao0, i);
            end
            $display("[TB] idle addr=%0d d=%0d", i, d0);
        end
        tests++;
        if (l0 !== 16'd0 || r0 !== 16'd0 || u0c !== 16'd0) begin
            fails++; $display("FAIL idle_counters got l=%0d r=%0d u=%0d want 0 0 0", l0, r0, u0c);
        end
    endtask

    task automatic test_root_split();
        logic [6:0] addrs [4] = '{7'h00, 7'h3F, 7'h40, 7'h7F};
        logic [1:0] exp   [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
        for (int i = 0; i < 4; i++) begin
            v0 = 1'b1; a0 = addrs[i];
            tick();
            tests++;
            if (d0 !== exp[i] || vo0 !== 1'b1 || ao0 !== addrs[i]) begin
                fails++; $display("FAIL root_%0h got d=%0d v=%0d a=%0h want d=%0d v=1", addrs[i], d0, vo0, ao0, exp[i]);
            end
            $display("[TB] root addr=%0h d=%0d", addrs[i], d0);
        end
        tests++;
        if (l0 !== 16'd2 || r0 !== 16'd2 || u0c !== 16'd0) begin
            fails++; $display("FAIL root_counters got l=%0d r=%0d u=%0d want 2 2 0", l0, r0, u0c);
        end
        v0 = 1'b0;
    endtask

    task automatic test_inner_node();
        logic [3:0] addrs [4] = '{4'b1000, 4'b1011, 4'b0110, 4'b1101};
        logic [1:0] exp   [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
        for (int i = 0; i < 4; i++) begin
            v1 = 1'b1; a1 = addrs[i];
            #1;
            tests++;
            if (i > 0 && d1 !== exp[i-1]) begin
                fails++; $display("FAIL inner_latency_%0d got d=%0d before edge want %0d", i, d1, exp[i-1]);
            end
            tick();
            tests++;
            if (d1 !== exp[i] || ao1 !== addrs[i]) begin
                fails++; $display("FAIL inner_%b got d=%0d a=%b want d=%0d", addrs[i], d1, ao1, exp[i]);
            end
            $display("[TB] inner addr=%b d=%0d", addrs[i], d1);
        end
        tests++;
        if (l1 !== 16'd1 || r1 !== 16'd1 || u1c !== 16'd2) begin
            fails++; $display("FAIL inner_counters got l=%0d r=%0d u=%0d want 1 1 2", l1, r1, u1c);
        end
        v1 = 1'b0;
    endtask

    task automatic test_leaf_adjacent();
        logic [2:0] addrs [3] = '{3'b010, 3'b011, 3'b111};
        logic [1:0] exp   [3] = '{2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 3; i++) begin
            v2 = 1'b1; a2 = addrs[i];
            tick();
            tests++;
            if (d2 !== exp[i] || vo2 !== 1'b1) begin
                fails++; $display("FAIL leaf_%b got d=%0d v=%0d want d=%0d v=1", addrs[i], d2, vo2, exp[i]);
            end
            $display("[TB] leaf addr=%b d=%0d", addrs[i], d2);
        end
        v2 = 1'b0;
        tick();
        tests++;
        if (d2 !== 2'b00 || vo2 !== 1'b0) begin
            fails++; $display("FAIL leaf_void got d=%0d v=%0d want 0 0", d2, vo2);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            v3 = 1'b1; a3 = 4'b0110;
            tick();
            tests++;
            if (u3c !== exp[i] || d3 !== 2'b11) begin
                fails++; $display("FAIL sat_%0d got cnt_up=%0d d=%0d want cnt_up=%0d d=3", i, u3c, d3, exp[i]);
            end
            $display("[TB] sat step=%0d cnt_up=%0d", i, u3c);
        end
    endtask

    task automatic test_clear();
        v3 = 1'b1; a3 = 4'b0110; c3 = 1'b1;
        tick();
        tests++;
        if (u3c !== 2'd0 || d3 !== 2'b11) begin
            fails++; $display("FAIL clear got cnt_up=%0d d=%0d want cnt_up=0 d=3", u3c, d3);
        end
        $display("[TB] clear cnt_up=%0d", u3c);
        c3 = 1'b0;
        tick();
        tests++;
        if (u3c !== 2'd1) begin
            fails++; $display("FAIL clear_resume got cnt_up=%0d want 1", u3c);
        end
    endtask

    task automatic test_async_reset();
        v3 = 1'b1; a3 = 4'b1101;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (d3 !== 2'b00 || vo3 !== 1'b0 || ao3 !== 4'd0 || u3c !== 2'd0) begin
            fails++; $display("FAIL async_reset got d=%0d v=%0d a=%0d u=%0d want all 0", d3, vo3, ao3, u3c);
        end
        $display("[TB] async reset d=%0d cnt_up=%0d", d3, u3c);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tests++;
        if (d3 !== 2'b11 || vo3 !== 1'b1 || ao3 !== 4'b1101 || u3c !== 2'd1) begin
            fails++; $display("FAIL async_release got d=%0d v=%0d a=%b u=%0d want d=3 v=1 a=1101 u=1", d3, vo3, ao3, u3c);
        end
    endtask

    initial begin
        test_reset();
        test_idle_sweep();
        test_root_split();
        test_inner_node();
        test_leaf_adjacent();
        test_saturation();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
